shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Multi-cycle shift unit controller. Accepts a shift request (data, amount, op) over a valid/ready handshake. Performs the shift one bit position per clock using a single-bit shift step. Returns the result over a valid/ready handshake. Used in front of the ALU shift path where area matters more than latency; supports SLL, SRL and SRA.

Parameters:
N, 32, data width in bits; shamt width is $clog2(N).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  request present
in_ready  output  1  block can accept a request (high only in IDLE)
in_data  input  N  operand to shift
in_shamt  input  $clog2(N)  shift amount, 0..N-1
in_op  input  2  shift_op_t: SLL=0, SRL=1, SRA=2; 3 reserved
out_valid  output  1  result present (high only in DONE)
out_ready  input  1  consumer accepts result
out_data  output  N  shifted result
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, data_r=0, count_r=0, op_r=SLL. Outputs: in_ready=1, out_valid=0, out_data=0, busy=0.
- rst has priority over all other inputs and may arrive at any time. Reset mid-SHIFT or mid-DONE discards the operation with no out_valid pulse.
- States: IDLE, SHIFT, DONE (enum in package).
- IDLE:
  - in_ready=1.
  - On edge E0 with in_valid=1: data_r<=in_data, count_r<=in_shamt, op_r<=in_op.
  - Next state is DONE if in_shamt==0, else SHIFT.
- SHIFT, each edge:
  - data_r<=step(data_r, op_r); count_r<=count_r-1.
  - If count_r==1, next state is DONE.
  - in_valid is ignored (in_ready=0).
- step() per op:
  - SLL: {data[N-2:0],1'b0}.
  - SRL: {1'b0,data[N-1:1]}.
  - SRA: {data[N-1],data[N-1:1]}.
  - Reserved op 3: treated as SLL.
- DONE:
  - out_valid=1, out_data=data_r.
  - Held stable while out_ready=0 (no timeout).
  - On edge with out_ready=1: next state IDLE.
  - No same-cycle accept of a new request in DONE; in_ready stays 0.
- Latency: request accepted at edge E0 with amount s. DONE entered after edge E_s (E0 for s=0). out_valid is therefore high s+1 cycles after the accept cycle begins.
- Throughput: at most one request per s+2 cycles, assuming out_ready=1.
- out_data outside DONE is 0 (gated), so consumers never see partial shifts.
- Count arithmetic: count_r is $clog2(N) bits, unsigned, decremented only in SHIFT. It never underflows because SHIFT is left when count_r==1.
- Maximum amount N-1=31: 31 SHIFT cycles, result is correct for all ops (SRA of negative value yields all ones).
- in_valid=1 held across DONE->IDLE: accepted on the first IDLE edge.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [1:0] shift_op_t {SHIFT_SLL, SHIFT_SRL, SHIFT_SRA}.
  - typedef enum logic [1:0] shift_state_t {S_IDLE, S_SHIFT, S_DONE}.
- One combinational sub-module shift_step (in N bits, op shift_op_t, out N bits) implements the single-bit shift. The sequencer holds the FSM, the count and the data register.

Test Plan:
- SLL: in_data=32'h0000_0001, shamt=4, op=SLL, out_ready=1 -> out_valid 5 cycles after accept cycle start, out_data=32'h0000_0010; in_ready low cycles 1-5, back high after.
- SRA negative, max amount: in_data=32'h8000_0000, shamt=31 -> out_data=32'hFFFF_FFFF after 32 cycles. Same with SRL -> 32'h0000_0001.
- Zero amount: in_data=32'hDEAD_BEEF, shamt=0, op=SRL -> out_valid the cycle after accept, out_data=32'hDEAD_BEEF.
- Backpressure: SLL 32'h0000_00FF by 8 with out_ready=0 for 10 cycles after DONE:
  - out_valid=1 and out_data=32'h0000_FF00 stable throughout.
  - in_ready=0 throughout.
  - Returns to IDLE one edge after out_ready=1.
- Busy ignore: second request (in_valid=1, 32'h1, shamt=1) asserted during SHIFT of the first -> ignored; first result unaffected. The second request is accepted only once IDLE is reached if still held.
- Reset mid-op: assert rst for one cycle at SHIFT cycle 3 of an SRA by 20 -> next cycle state IDLE, out_valid=0, out_data=0, in_ready=1, busy=0, and no out_valid pulse ever appears for the aborted request.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift sequencer.
package shift_pkg;

    // Shift operation; encoding 2'd3 is reserved and handled as SLL.
    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2
    } shift_op_t;

    // Sequencer control states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } shift_state_t;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// Single-bit-position shift step used once per SHIFT cycle.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] in,
    input  shift_op_t    op,
    output logic [N-1:0] out
);

    // One-position shift; any encoding outside SRL/SRA (including reserved 3) shifts left.
    always_comb begin
        out = {in[N-2:0], 1'b0};
        case (op)
            SHIFT_SRL: out = {1'b0, in[N-1:1]};
            SHIFT_SRA: out = {in[N-1], in[N-1:1]};
            default:   out = {in[N-2:0], 1'b0};
        endcase
    end

endmodule : shift_step

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: accepts a request, shifts one position per
// clock, then presents the result until the consumer accepts it.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_shamt,
    input  shift_op_t            in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic                 busy
);

    localparam int unsigned SW = $clog2(N);
    localparam logic [SW-1:0] CNT_ONE = SW'(1);

    shift_state_t  state_q;
    shift_state_t  state_d;
    logic [N-1:0]  data_r;
    logic [SW-1:0] count_r;
    shift_op_t     op_r;
    logic [N-1:0]  step_out;

    shift_step #(
        .N (N)
    ) u_step (
        .in  (data_r),
        .op  (op_r),
        .out (step_out)
    );

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: zero amount skips SHIFT; SHIFT exits when the last step is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = (in_shamt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (count_r == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture on accept, one shift step and count decrement per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= '0;
            count_r <= '0;
            op_r    <= SHIFT_SLL;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        data_r  <= in_data;
                        count_r <= in_shamt;
                        op_r    <= in_op;
                    end
                end
                S_SHIFT: begin
                    data_r  <= step_out;
                    count_r <= count_r - CNT_ONE;
                end
                default: begin
                    data_r  <= data_r;
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Handshake outputs; result is gated so partial shifts are never visible.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_SHIFT: begin
                busy = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
                out_data  = data_r;
                busy      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a result scoreboard.
module tb_shift_sequencer;
    import shift_pkg::*;

    localparam int unsigned N = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [4:0]    in_shamt;
    shift_op_t     in_op;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          busy;

    int unsigned   total = 0;
    int unsigned   bad   = 0;
    logic [N-1:0]  exp_q[$];

    shift_sequencer #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] model(input logic [N-1:0] d, input int s, input shift_op_t op);
        logic [N-1:0] r;
        case (op)
            SHIFT_SRL: r = d >> s;
            SHIFT_SRA: r = $signed(d) >>> s;
            default:   r = d << s;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_in_ready"}, N'(in_ready), N'(1));
        check({tag, "_out_valid"}, N'(out_valid), N'(0));
        check({tag, "_out_data"}, out_data, '0);
        check({tag, "_busy"}, N'(busy), N'(0));
    endtask

    // Present a request in IDLE; it is accepted on the next edge.
    task automatic send(input logic [N-1:0] d, input int s, input shift_op_t op);
        check("pre_accept_ready", N'(in_ready), N'(1));
        in_data  = d;
        in_shamt = 5'(s);
        in_op    = op;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_q.push_back(model(d, s, op));
        check("accept_in_ready_low", N'(in_ready), N'(0));
        check("accept_busy", N'(busy), N'(1));
    endtask

    // Wait (bounded) for out_valid and score latency and data.
    task automatic expect_result(input int s, input string tag);
        int k = 0;
        logic [N-1:0] e;
        while (!out_valid && k < 64) begin
            check({tag, "_in_ready_while_busy"}, N'(in_ready), N'(0));
            tick();
            k++;
        end
        check({tag, "_latency"}, N'(k), N'(s));
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check({tag, "_data"}, out_data, e);
    endtask

    task automatic full_op(input logic [N-1:0] d, input int s, input shift_op_t op, input string tag);
        send(d, s, op);
        expect_result(s, tag);
        tick();
        expect_idle({tag, "_after"});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = SHIFT_SLL;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        expect_idle("reset");

        full_op(32'h0000_0001, 4, SHIFT_SLL, "sll4");
        full_op(32'h8000_0000, 31, SHIFT_SRA, "sra31");
        full_op(32'h8000_0000, 31, SHIFT_SRL, "srl31");
        full_op(32'hDEAD_BEEF, 0, SHIFT_SRL, "zero_amt");
        full_op(32'h7000_00F0, 3, SHIFT_SRA, "sra_pos");
        full_op(32'h0000_0001, 2, shift_op_t'(2'd3), "reserved_op");
        full_op(32'h8000_0001, 31, SHIFT_SLL, "sll31");
        for (int i = 0; i < 4; i++) begin
            full_op($urandom, int'($urandom_range(0, 31)), shift_op_t'($urandom_range(0, 2)), "rand");
        end

        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        send(32'h0000_00FF, 8, SHIFT_SLL);
        expect_result(8, "bp");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", N'(out_valid), N'(1));
            check("bp_hold_data", out_data, 32'h0000_FF00);
            check("bp_hold_in_ready", N'(in_ready), N'(0));
        end
        out_ready = 1'b1;
        tick();
        expect_idle("bp_release");

        // Second request held during SHIFT is ignored until IDLE.
        send(32'h0000_0003, 6, SHIFT_SLL);
        in_data  = 32'h0000_0001;
        in_shamt = 5'd1;
        in_op    = SHIFT_SLL;
        in_valid = 1'b1;
        expect_result(6, "busy_first");
        tick();
        check("busy_idle_ready", N'(in_ready), N'(1));
        check("busy_idle_valid", N'(out_valid), N'(0));
        tick();
        in_valid = 1'b0;
        exp_q.push_back(32'h0000_0002);
        check("busy_second_accepted", N'(in_ready), N'(0));
        expect_result(1, "busy_second");
        tick();
        expect_idle("busy_after");

        // Reset during SHIFT cycle 3 of an SRA by 20.
        send(32'hF000_1234, 20, SHIFT_SRA);
        tick();
        tick();
        check("abort_pre_busy", N'(busy), N'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(exp_q.pop_back());
        expect_idle("abort");
        begin
            int pulses = 0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (out_valid) pulses++;
            end
            check("abort_no_pulse", N'(pulses), N'(0));
        end
        expect_idle("abort_end");

        full_op(32'h0000_00A5, 5, SHIFT_SRL, "post_abort");
        check("scoreboard_empty", N'(exp_q.size()), N'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_sequencer
